// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types, T-state encodings and control-word constants for the SAP control unit
package cpu_pkg;

    typedef struct packed {
        logic hlt;
        logic mi;
        logic ri;
        logic ro;
        logic io;
        logic ii;
        logic ai;
        logic ao;
        logic eo;
        logic su;
        logic bi;
        logic oi;
        logic ce;
        logic co;
        logic j;
        logic fi;
    } ctrl_word_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'b0000,
        OP_LDA = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_STA = 4'b0100,
        OP_LDI = 4'b0101,
        OP_JMP = 4'b0110,
        OP_JC  = 4'b0111,
        OP_JZ  = 4'b1000,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_t;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    // Bit order: hlt mi ri ro io ii ai ao eo su bi oi ce co j fi (hlt is bit 15)
    localparam ctrl_word_t CW_NONE   = 16'h0000;
    localparam ctrl_word_t CW_FETCH0 = 16'h4004;
    localparam ctrl_word_t CW_FETCH1 = 16'h1408;
    localparam ctrl_word_t CW_IO_MI  = 16'h4800;
    localparam ctrl_word_t CW_RO_AI  = 16'h1200;
    localparam ctrl_word_t CW_RO_BI  = 16'h1020;
    localparam ctrl_word_t CW_ADD    = 16'h0281;
    localparam ctrl_word_t CW_SUB    = 16'h02C1;
    localparam ctrl_word_t CW_AO_RI  = 16'h2100;
    localparam ctrl_word_t CW_IO_AI  = 16'h0A00;
    localparam ctrl_word_t CW_JUMP   = 16'h0802;
    localparam ctrl_word_t CW_OUT    = 16'h0110;
    localparam ctrl_word_t CW_HLT    = 16'h8000;

endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: opcode/flag inputs and control-word outputs between the sequencer and the datapath
interface control_unit_if;
    import cpu_pkg::*;

    logic [3:0] opcode;
    logic       carry_flag;
    logic       zero_flag;
    ctrl_word_t ctrl;
    logic [2:0] step;
    logic       halted;

    modport master (
        input  opcode, carry_flag, zero_flag,
        output ctrl, step, halted
    );

    modport slave (
        output opcode, carry_flag, zero_flag,
        input  ctrl, step, halted
    );

endinterface

// File: rtl/microcode_rom.sv
// microcode_rom: combinational lookup of control word and last-step flag per opcode and T-state
module microcode_rom
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [2:0] step,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output ctrl_word_t cw,
    output logic       last
);

    ctrl_word_t exec;
    logic [2:0] last_step;

    // Execute-phase word and final T-state per opcode; fetch words override T0/T1
    always_comb begin
        exec      = CW_NONE;
        last_step = T1;
        case (opcode_t'(opcode))
            OP_LDA: begin
                last_step = T3;
                exec      = step == T2 ? CW_IO_MI : step == T3 ? CW_RO_AI : CW_NONE;
            end
            OP_ADD: begin
                last_step = T4;
                exec      = step == T2 ? CW_IO_MI : step == T3 ? CW_RO_BI : step == T4 ? CW_ADD : CW_NONE;
            end
            OP_SUB: begin
                last_step = T4;
                exec      = step == T2 ? CW_IO_MI : step == T3 ? CW_RO_BI : step == T4 ? CW_SUB : CW_NONE;
            end
            OP_STA: begin
                last_step = T3;
                exec      = step == T2 ? CW_IO_MI : step == T3 ? CW_AO_RI : CW_NONE;
            end
            OP_LDI: begin
                last_step = T2;
                exec      = step == T2 ? CW_IO_AI : CW_NONE;
            end
            OP_JMP: begin
                last_step = T2;
                exec      = step == T2 ? CW_JUMP : CW_NONE;
            end
            OP_JC: begin
                last_step = T2;
                exec      = (step == T2 && carry_flag) ? CW_JUMP : CW_NONE;
            end
            OP_JZ: begin
                last_step = T2;
                exec      = (step == T2 && zero_flag) ? CW_JUMP : CW_NONE;
            end
            OP_OUT: begin
                last_step = T2;
                exec      = step == T2 ? CW_OUT : CW_NONE;
            end
            OP_HLT: begin
                last_step = T2;
                exec      = step == T2 ? CW_HLT : CW_NONE;
            end
            default: begin
                last_step = T1;
                exec      = CW_NONE;
            end
        endcase
        cw   = step == T0 ? CW_FETCH0 : step == T1 ? CW_FETCH1 : exec;
        last = step == last_step;
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: T-state counter and halt latch driving the microcoded SAP control word
module control_unit
    import cpu_pkg::*;
#(
    parameter int NSTEPS = 5
) (
    input  logic           CLK,
    input  logic           RST,
    control_unit_if.master bus
);

    localparam int SW = $clog2(NSTEPS);
    localparam logic [SW-1:0] STEP_MAX = SW'(NSTEPS - 1);

    logic [SW-1:0] step_q;
    logic          halted_q;
    logic [2:0]    step_w;
    ctrl_word_t    cw;
    logic          last;

    assign step_w = 3'(step_q);

    microcode_rom rom (
        .opcode     (bus.opcode),
        .step       (step_w),
        .carry_flag (bus.carry_flag),
        .zero_flag  (bus.zero_flag),
        .cw         (cw),
        .last       (last)
    );

    // Advance the T-state, wrapping after the opcode's last step; a T2 hlt freezes the counter at T2
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            step_q   <= '0;
            halted_q <= 1'b0;
        end else if (!halted_q) begin
            if (cw.hlt && step_w == T2)
                halted_q <= 1'b1;
            else
                step_q <= (last || step_q == STEP_MAX) ? '0 : step_q + 1'b1;
        end
    end

    assign bus.ctrl   = halted_q ? CW_HLT : cw;
    assign bus.step   = step_w;
    assign bus.halted = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed-vector check of the SAP control sequencer
module tb_control_unit;

    localparam int B_HLT = 15, B_MI = 14, B_RI = 13, B_RO = 12, B_IO = 11, B_II = 10, B_AI = 9, B_AO = 8;
    localparam int B_EO = 7, B_SU = 6, B_BI = 5, B_OI = 4, B_CE = 3, B_CO = 2, B_J = 1, B_FI = 0;

    localparam logic [15:0] E_NONE = 16'h0;
    localparam logic [15:0] E_F0   = (16'h1 << B_MI) | (16'h1 << B_CO);
    localparam logic [15:0] E_F1   = (16'h1 << B_RO) | (16'h1 << B_II) | (16'h1 << B_CE);
    localparam logic [15:0] E_IOMI = (16'h1 << B_IO) | (16'h1 << B_MI);
    localparam logic [15:0] E_ROAI = (16'h1 << B_RO) | (16'h1 << B_AI);
    localparam logic [15:0] E_ROBI = (16'h1 << B_RO) | (16'h1 << B_BI);
    localparam logic [15:0] E_ADD  = (16'h1 << B_EO) | (16'h1 << B_AI) | (16'h1 << B_FI);
    localparam logic [15:0] E_SUB  = E_ADD | (16'h1 << B_SU);
    localparam logic [15:0] E_AORI = (16'h1 << B_AO) | (16'h1 << B_RI);
    localparam logic [15:0] E_IOAI = (16'h1 << B_IO) | (16'h1 << B_AI);
    localparam logic [15:0] E_JUMP = (16'h1 << B_IO) | (16'h1 << B_J);
    localparam logic [15:0] E_OUT  = (16'h1 << B_AO) | (16'h1 << B_OI);
    localparam logic [15:0] E_HLT  = 16'h1 << B_HLT;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    control_unit_if bus();

    control_unit dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic state(input string tag, input logic [2:0] s, input logic [15:0] c, input logic h);
        check({tag, ".step"}, 16'(bus.step), 16'(s));
        check({tag, ".ctrl"}, 16'(bus.ctrl), c);
        check({tag, ".halted"}, 16'(bus.halted), 16'(h));
        check({tag, ".j_ce"}, 16'(bus.ctrl.j & bus.ctrl.ce), 16'h0);
    endtask

    task automatic cyc(input string tag, input logic [2:0] s, input logic [15:0] c);
        state(tag, s, c, 1'b0);
        @(negedge clk);
    endtask

    task automatic fetch(input string tag, input logic [3:0] op);
        bus.opcode = op;
        cyc({tag, ".t0"}, 3'd0, E_F0);
        cyc({tag, ".t1"}, 3'd1, E_F1);
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        bus.opcode     = 4'b0000;
        bus.carry_flag = 1'b0;
        bus.zero_flag  = 1'b0;
        #2;
        state("reset", 3'd0, E_F0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        fetch("nop_a", 4'b0000);
        fetch("nop_b", 4'b0000);

        fetch("add", 4'b0010);
        cyc("add.t2", 3'd2, E_IOMI);
        cyc("add.t3", 3'd3, E_ROBI);
        cyc("add.t4", 3'd4, E_ADD);

        fetch("sub", 4'b0011);
        cyc("sub.t2", 3'd2, E_IOMI);
        cyc("sub.t3", 3'd3, E_ROBI);
        cyc("sub.t4", 3'd4, E_SUB);

        fetch("lda", 4'b0001);
        cyc("lda.t2", 3'd2, E_IOMI);
        cyc("lda.t3", 3'd3, E_ROAI);

        fetch("sta", 4'b0100);
        cyc("sta.t2", 3'd2, E_IOMI);
        cyc("sta.t3", 3'd3, E_AORI);

        fetch("ldi", 4'b0101);
        cyc("ldi.t2", 3'd2, E_IOAI);

        fetch("jmp", 4'b0110);
        cyc("jmp.t2", 3'd2, E_JUMP);

        fetch("out", 4'b1110);
        cyc("out.t2", 3'd2, E_OUT);

        bus.carry_flag = 1'b1;
        fetch("jc1", 4'b0111);
        cyc("jc1.t2", 3'd2, E_JUMP);

        bus.carry_flag = 1'b0;
        bus.zero_flag  = 1'b1;
        fetch("jc0", 4'b0111);
        cyc("jc0.t2", 3'd2, E_NONE);

        fetch("jz1", 4'b1000);
        cyc("jz1.t2", 3'd2, E_JUMP);

        bus.zero_flag  = 1'b0;
        bus.carry_flag = 1'b1;
        fetch("jz0", 4'b1000);
        state("jz0.t2", 3'd2, E_NONE, 1'b0);
        bus.zero_flag = 1'b1;
        #1;
        check("jz_live.ctrl", 16'(bus.ctrl), E_JUMP);
        @(negedge clk);
        bus.zero_flag  = 1'b0;
        bus.carry_flag = 1'b0;

        fetch("undef_a", 4'b1011);
        fetch("undef_b", 4'b1011);

        fetch("lda_rst", 4'b0001);
        cyc("lda_rst.t2", 3'd2, E_IOMI);
        state("lda_rst.t3", 3'd3, E_ROAI, 1'b0);
        #2 rst = 1'b1;
        #1 state("lda_rst.async", 3'd0, E_F0, 1'b0);
        #1 rst = 1'b0;
        @(negedge clk);
        cyc("lda_rst.after", 3'd1, E_F1);
        cyc("lda_rst.t2b", 3'd2, E_IOMI);
        cyc("lda_rst.t3b", 3'd3, E_ROAI);

        fetch("hlt", 4'b1111);
        cyc("hlt.t2", 3'd2, E_HLT);
        for (int i = 0; i < 20; i++) begin
            state("halted", 3'd2, E_HLT, 1'b1);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1 state("hlt_rst", 3'd0, E_F0, 1'b0);
        #1 rst = 1'b0;
        bus.opcode = 4'b0000;
        @(negedge clk);
        cyc("hlt_rst.after", 3'd1, E_F1);
        cyc("hlt_rst.t0", 3'd0, E_F0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Microcoded control sequencer for the 8-bit SAP CPU. It steps through the fetch/execute T-states, decodes the 4-bit opcode held in the instruction register, and drives one control word per cycle. That word sequences the program counter (count, output, jump-load) together with the MAR, RAM, IR, A/B registers, ALU, flags and output register. It sits between the instruction register / flags register and every datapath block.

## Interface
Parameters:
- NSTEPS, 5, number of T-states (T0..T4); step counter width is $clog2(NSTEPS).

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST  in  1  asynchronous, active-high reset.
- opcode  in  4  upper nibble of the instruction register.
- carry_flag  in  1  registered carry from the flags register.
- zero_flag  in  1  registered zero from the flags register.
- ctrl  out  ctrl_word_t (16)  control word: hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi.
- step  out  3  current T-state, for debug and the display.
- halted  out  1  processor halted.

## Operation
- Opcodes:
  - NOP=0000, LDA=0001, ADD=0010, SUB=0011, STA=0100, LDI=0101
  - JMP=0110, JC=0111, JZ=1000, OUT=1110, HLT=1111
  - 1001–1101 are undefined and execute as NOP.
- Fetch, common to all opcodes:
  - T0: mi|co.
  - T1: ro|ii|ce.
- Execute:
  - LDA: T2 io|mi; T3 ro|ai (last step T3).
  - ADD: T2 io|mi; T3 ro|bi; T4 eo|ai|fi (last T4).
  - SUB: as ADD, with su also asserted in T4 (last T4).
  - STA: T2 io|mi; T3 ao|ri (last T3).
  - LDI: T2 io|ai (last T2).
  - JMP: T2 io|j (last T2).
  - JC: T2 io|j if carry_flag=1, otherwise empty word; last step T2 either way.
  - JZ: T2 io|j if zero_flag=1, otherwise empty word; last step T2 either way.
  - OUT: T2 ao|oi (last T2).
  - HLT: T2 hlt (last T2).
  - NOP/undefined: last step T1.
- Step counter:
  - Advances by 1 each cycle.
  - Returns to T0 on the cycle after the opcode's last step (variable-length instructions).
  - Never exceeds NSTEPS-1; T4 always wraps to T0.
- Halt:
  - At the posedge ending a T2 in which hlt=1, halted is set.
  - While halted: step frozen at T2, ctrl = hlt only, all other bits 0.
  - Only RST clears halted.
- The ctrl j bit drives the PC's jump-load input; ce drives its count enable.
- Within one control word, j and ce are never both 1.

## Timing
- ctrl, step and halted are combinational from the registered state (step, halted) plus the opcode and flag inputs. No added latency: a datapath block acts on its ctrl bits at the same posedge that advances step.
- opcode is only meaningful from T2 onward; the IR loads at the end of T1.
- Flags are sampled combinationally during T2; a flag change in T2 changes the same-cycle j.
- Reset, asynchronous, takes effect immediately: step=0, halted=0, ctrl=mi|co, all other ctrl bits 0.
- Reset mid-instruction or while halted: same values; the next posedge begins a fresh fetch.
- Cycle counts per instruction:
  - NOP: 2.
  - LDI, JMP, JC, JZ, OUT: 3.
  - LDA, STA: 4.
  - ADD, SUB: 5.

## Structure
- cpu_pkg contains:
  - ctrl_word_t, a packed struct in the bit order listed above.
  - opcode_t enum.
  - Step localparams T0..T4.
  - CW_* control-word constants for each microinstruction.
- Sub-module microcode_rom: purely combinational, (opcode, step, carry, zero) -> {ctrl_word_t, last_step}.
- control_unit holds only the step counter, the halted register, and the halt override.

## Test plan
- Reset, then hold opcode=0000 -> step sequence 0,1,0,1…; ctrl alternates mi|co then ro|ii|ce; halted=0.
- opcode=0010 (ADD) -> steps 0..4 then 0; T4 ctrl = eo|ai|fi with su=0. Repeat with 0011 -> T4 additionally has su=1.
- opcode=0111 (JC):
  - carry=1 -> T2 ctrl = io|j.
  - carry=0 -> T2 ctrl = 0.
  - Both cases return to T0 after 3 cycles.
  - Repeat for JZ using zero_flag.
- opcode=1111 -> T2 asserts hlt; from the next cycle halted=1, step stuck at 2 for 20 cycles, ctrl=hlt only. Assert RST -> step=0, ctrl=mi|co immediately.
- opcode=1011 (undefined) -> behaves exactly as NOP (2-cycle loop, no execute bits).
- Assert RST asynchronously (between clock edges) during T3 of LDA -> outputs take reset values before the next edge; the following posedge gives step=1.
